// File: rtl/booth_multiplier_synth.sv
// booth_multiplier_synth
// Pipelined 16x16 signed radix-4 Booth multiplier with a full 32-bit product.
// A new operand pair is accepted on every rising edge of clk. The product
// appears two edges after its operands are captured.
//
// Ports:
//   clk          - single clock, rising-edge active
//   rst          - asynchronous active-high reset; clears every pipeline register
//   multiplicand - signed operand A (16 bits)
//   multiplier   - signed operand B (16 bits); drives the Booth recoding
//   product      - registered signed A*B (32 bits)
//
// Pipeline:
//   stage 0 : input operand registers
//   stage 1 : Booth partial products and a 3:2 carry-save tree, registered as a sum/carry pair
//   stage 2 : carry-propagate add of sum+carry, registered into product

module booth_multiplier_synth (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [31:0] product
);

    localparam int unsigned OP_W       = 16;
    localparam int unsigned PROD_W     = 32;
    localparam int unsigned NUM_DIGITS = OP_W / 2;
    // Eight Booth rows, plus one row that collects the +1 of each negation
    localparam int unsigned NUM_ROWS   = NUM_DIGITS + 1;

    // ------------------------------------------------------------------
    // Stage 0: operand capture
    // ------------------------------------------------------------------
    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= multiplicand;
            b_q <= multiplier;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: Booth recoding and partial-product generation
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] a_ext;
    logic [OP_W:0]     b_ext;
    logic [PROD_W-1:0] pp [NUM_ROWS];
    logic [PROD_W-1:0] neg_corr;

    assign a_ext = {{(PROD_W - OP_W){a_q[OP_W-1]}}, a_q};
    // b_ext[0] is the implicit B[-1] = 0
    assign b_ext = {b_q, 1'b0};

    // The negation +1 for digit i lands on bit 2i of neg_corr. These bits never
    // overlap, so neg_corr goes into the tree as one extra row and no adder
    // sits in front of the tree.
    assign neg_corr[PROD_W-1:2*NUM_DIGITS] = '0;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [2:0]        trip;
        logic              sel_one;
        logic              sel_two;
        logic              neg;
        logic [PROD_W-1:0] mag;

        assign trip    = b_ext[2*i +: 3];
        assign sel_one = trip[1] ^ trip[0];
        assign sel_two = (trip == 3'b011) || (trip == 3'b100);
        assign neg     = trip[2];

        assign mag = sel_one ? a_ext
                   : sel_two ? {a_ext[PROD_W-2:0], 1'b0}
                   : '0;

        // -(m << 2i) == (~m << 2i) + 2^(2i). The 2^(2i) term is carried in neg_corr.
        // For trip 111, neg is set with m = 0, so the row sums to zero.
        assign pp[i] = (neg ? ~mag : mag) << (2 * i);

        assign neg_corr[2*i]     = neg;
        assign neg_corr[2*i + 1] = 1'b0;
    end

    assign pp[NUM_DIGITS] = neg_corr;

    // ------------------------------------------------------------------
    // Stage 1: 3:2 carry-save tree, 9 rows -> 6 -> 4 -> 3 -> 2
    // ------------------------------------------------------------------
    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // Carries move up one weight. Bit 31 is dropped because the result is mod 2^32.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [PROD_W-1:0] l1_s [3];
    logic [PROD_W-1:0] l1_c [3];
    logic [PROD_W-1:0] l2a_s, l2a_c;
    logic [PROD_W-1:0] l2b_s, l2b_c;
    logic [PROD_W-1:0] l3_s, l3_c;
    logic [PROD_W-1:0] tree_sum, tree_carry;

    // Level 1: three independent groups of three rows
    for (genvar g = 0; g < 3; g++) begin : g_lvl1
        assign l1_s[g] = csa_sum  (pp[3*g], pp[3*g + 1], pp[3*g + 2]);
        assign l1_c[g] = csa_carry(pp[3*g], pp[3*g + 1], pp[3*g + 2]);
    end

    // Level 2: six rows -> four rows
    assign l2a_s = csa_sum  (l1_s[0], l1_c[0], l1_s[1]);
    assign l2a_c = csa_carry(l1_s[0], l1_c[0], l1_s[1]);
    assign l2b_s = csa_sum  (l1_c[1], l1_s[2], l1_c[2]);
    assign l2b_c = csa_carry(l1_c[1], l1_s[2], l1_c[2]);

    // Level 3: four rows -> three rows (l2b_c passes through)
    assign l3_s = csa_sum  (l2a_s, l2a_c, l2b_s);
    assign l3_c = csa_carry(l2a_s, l2a_c, l2b_s);

    // Level 4: three rows -> final sum/carry pair
    assign tree_sum   = csa_sum  (l3_s, l3_c, l2b_c);
    assign tree_carry = csa_carry(l3_s, l3_c, l2b_c);

    logic [PROD_W-1:0] sum_q;
    logic [PROD_W-1:0] carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= tree_sum;
            carry_q <= tree_carry;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: final carry-propagate add, modulo 2^32
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else begin
            product <= PROD_W'(sum_q + carry_q);
        end
    end

endmodule

// File: tb/tb_booth_multiplier_synth.sv
// Self-checking bench for booth_multiplier_synth.
// The reference keeps a history of the signed products of every captured operand
// pair. The expected output is the entry captured two edges earlier.
module tb_booth_multiplier_synth;

    logic        clk;
    logic        rst;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] hist [$];

    booth_multiplier_synth dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    function automatic logic [31:0] model_expected();
        if (hist.size() >= 3) return hist[hist.size() - 3];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one operand pair across one rising edge, then compare against the model.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input string tag);
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        if (rst) hist.delete();
        else begin
            hist.push_back(ref_mul(a, b));
            if (hist.size() > 4) void'(hist.pop_front());
        end
        #1;
        chk(tag, product, model_expected());
    endtask

    // Hold one operand pair for three edges, then compare against a hand-derived constant.
    task automatic hold(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
        for (int k = 0; k < 3; k++) step(a, b, {tag, "_model"});
        chk(tag, product, exp);
    endtask

    logic [15:0] s_a   [6];
    logic [15:0] s_b   [6];
    logic [31:0] s_exp [4];
    logic [15:0] corner [6];

    initial begin
        rst          = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        chk("reset_initial", product, 32'h0);
        step(16'd100, 16'd12, "reset_held");
        step(16'd100, 16'd12, "reset_held");
        rst = 1'b0;

        hold(16'd100, 16'd12, 32'h0000_04B0, "pos_100x12");
        hold(16'd90,  16'd4,  32'd360,       "pos_90x4");
        hold(16'd85,  16'd30, 32'd2550,      "pos_85x30");

        // Assert reset in the middle of a cycle while a product is showing
        hold(16'd100, 16'd12, 32'h0000_04B0, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async", product, 32'h0);
        hist.delete();
        step(16'd0, 16'd0, "reset_mid_held");
        rst = 1'b0;
        step(16'd0, 16'd0, "post_reset_e1");
        chk("post_reset_const1", product, 32'h0);
        step(16'd0, 16'd0, "post_reset_e2");
        chk("post_reset_const2", product, 32'h0);
        hold(16'd0, 16'd5, 32'h0, "zero_x5");

        hold(16'hFFFF, 16'hFFFF, 32'h0000_0001, "neg1_neg1");
        hold(16'hFFFD, 16'd7,    32'hFFFF_FFEB, "neg3_x7");
        hold(16'h8000, 16'h8000, 32'h4000_0000, "min_min");
        hold(16'h8000, 16'h7FFF, 32'hC000_8000, "min_max");
        hold(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max_max");
        hold(16'h1234, 16'hAAAA, 32'hF9EE_9E88, "booth_aaaa");
        hold(16'h1234, 16'h5555, 32'h0611_4F44, "booth_5555");
        hold(16'h1234, 16'hFFFF, 32'hFFFF_EDCC, "booth_ffff");
        hold(16'h8000, 16'h0000, 32'h0,         "zero_b_neg_a");
        hold(16'h0000, 16'h8000, 32'h0,         "zero_a_neg_b");

        // Back-to-back stream with a new pair on every edge
        s_a = '{16'd100, 16'd90, 16'd85, 16'd0, 16'd0, 16'd0};
        s_b = '{16'd12,  16'd4,  16'd30, 16'd5, 16'd0, 16'd0};
        s_exp = '{32'd1200, 32'd360, 32'd2550, 32'd0};
        for (int k = 0; k < 6; k++) begin
            step(s_a[k], s_b[k], "stream_model");
            if (k >= 2) chk("stream_order", product, s_exp[k - 2]);
            else        chk("stream_lead", product, 32'h0);
        end

        // Random pairs, with corner operand values mixed in
        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hAAAA, 16'h5555};
        for (int n = 0; n < 12000; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) rb = corner[$urandom_range(0, 5)];
            step(ra, rb, "random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
